// File: rtl/sram_pkg.sv
// Shared constants for the SRAM controller and its datapath stage.
package sram_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 8;

    // Values carried on read_enable
    localparam logic MODE_READ  = 1'b1;
    localparam logic MODE_WRITE = 1'b0;

endpackage : sram_pkg

// File: rtl/sram_addr_counter.sv
// SRAM address counter: synchronous clear, increment, wrap at LAST with a one-cycle pulse.
module sram_addr_counter #(
    parameter int               WIDTH = 11,
    parameter logic [WIDTH-1:0] LAST  = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] addr_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] addr_q, addr_d;
    logic             wrap_q, wrap_d;

    // Next address: clear beats increment, and a cleared edge never reports a wrap.
    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        if (clear_i) begin
            addr_d = '0;
        end else if (inc_i) begin
            if (addr_q == LAST) begin
                addr_d = '0;
                wrap_d = 1'b1;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Address and wrap pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
        end
    end

    assign addr_o = addr_q;
    assign wrap_o = wrap_q;

endmodule : sram_addr_counter

// File: rtl/sram_datapath.sv
// Datapath stage behind the SRAM control FSM: address counter, write register,
// read capture and running checksums, plus the SRAM pin strobes.
module sram_datapath #(
    parameter int ADDR_WIDTH = sram_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_pkg::DATA_WIDTH,
    parameter int LAST_ADDR  = 2**ADDR_WIDTH - 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  increment,
    input  logic                  latch,
    input  logic                  data_valid,
    input  logic                  output_enable,
    input  logic                  read_enable,
    input  logic                  chip_select,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] sram_data_in,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_out,
    output logic                  sram_data_drive,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic                  sram_cs_n,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  wrap,
    output logic [DATA_WIDTH-1:0] wr_checksum,
    output logic [DATA_WIDTH-1:0] rd_checksum
);

    import sram_pkg::*;

    logic                  prev_mode_q;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] wr_sum_q, wr_sum_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] rd_sum_q, rd_sum_d;
    logic                  rd_valid_q, rd_valid_d;

    logic mode_change;
    logic in_write;
    logic in_read;
    logic do_latch;
    logic do_capture;

    assign mode_change = (read_enable != prev_mode_q);
    assign in_write    = (read_enable == MODE_WRITE);
    assign in_read     = (read_enable == MODE_READ);
    assign do_latch    = latch && in_write;
    // A mode change edge suppresses the capture so the fresh read checksum starts clean.
    assign do_capture  = in_read && !output_enable && !data_valid && !mode_change;

    sram_addr_counter #(
        .WIDTH (ADDR_WIDTH),
        .LAST  (ADDR_WIDTH'(LAST_ADDR))
    ) u_addr_counter (
        .clock   (clock),
        .reset   (reset),
        .clear_i (mode_change),
        .inc_i   (increment),
        .addr_o  (sram_addr),
        .wrap_o  (wrap)
    );

    // Next-state for write register, read capture and checksums.
    always_comb begin
        data_out_d = data_out_q;
        wr_sum_d   = wr_sum_q;
        rd_data_d  = rd_data_q;
        rd_sum_d   = rd_sum_q;
        rd_valid_d = do_capture;

        // Entering a mode restarts that mode's checksum; a latch on the same
        // edge then accumulates onto the cleared value.
        if (mode_change && in_write) wr_sum_d = '0;
        if (mode_change && in_read)  rd_sum_d = '0;

        if (do_latch) begin
            data_out_d = wr_data;
            wr_sum_d   = wr_sum_d + wr_data;
        end

        if (do_capture) begin
            rd_data_d = sram_data_in;
            rd_sum_d  = rd_sum_q + sram_data_in;
        end
    end

    // Datapath state registers; mode history resets to read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_mode_q <= MODE_READ;
            data_out_q  <= '0;
            wr_sum_q    <= '0;
            rd_data_q   <= '0;
            rd_sum_q    <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            prev_mode_q <= read_enable;
            data_out_q  <= data_out_d;
            wr_sum_q    <= wr_sum_d;
            rd_data_q   <= rd_data_d;
            rd_sum_q    <= rd_sum_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Pin strobes follow the controller but are forced inactive while reset is high.
    assign sram_oe_n       = reset | output_enable;
    assign sram_cs_n       = reset | chip_select;
    assign sram_data_drive = ~reset & ~read_enable;
    assign sram_we_n       = reset | ~(~read_enable & data_valid);

    assign sram_data_out = data_out_q;
    assign wr_checksum   = wr_sum_q;
    assign rd_data       = rd_data_q;
    assign rd_checksum   = rd_sum_q;
    assign rd_valid      = rd_valid_q;

endmodule : sram_datapath

// File: tb/tb_sram_datapath.sv
// Self-checking bench for sram_datapath: default build plus a LAST_ADDR=3 build sharing inputs.
module tb_sram_datapath;

    logic        clock = 1'b0;
    logic        reset;
    logic        increment, latch, data_valid, output_enable, read_enable, chip_select;
    logic [7:0]  wr_data, sram_data_in;

    logic [10:0] sram_addr;
    logic [7:0]  sram_data_out, rd_data, wr_checksum, rd_checksum;
    logic        sram_data_drive, sram_we_n, sram_oe_n, sram_cs_n, rd_valid, wrap;

    logic [10:0] s_addr;
    logic [7:0]  s_data_out, s_rd_data, s_wr_checksum, s_rd_checksum;
    logic        s_data_drive, s_we_n, s_oe_n, s_cs_n, s_rd_valid, s_wrap;

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    sram_datapath dut (
        .clock(clock), .reset(reset), .increment(increment), .latch(latch),
        .data_valid(data_valid), .output_enable(output_enable), .read_enable(read_enable),
        .chip_select(chip_select), .wr_data(wr_data), .sram_data_in(sram_data_in),
        .sram_addr(sram_addr), .sram_data_out(sram_data_out), .sram_data_drive(sram_data_drive),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_cs_n(sram_cs_n),
        .rd_data(rd_data), .rd_valid(rd_valid), .wrap(wrap),
        .wr_checksum(wr_checksum), .rd_checksum(rd_checksum)
    );

    sram_datapath #(.LAST_ADDR(3)) dut_s (
        .clock(clock), .reset(reset), .increment(increment), .latch(latch),
        .data_valid(data_valid), .output_enable(output_enable), .read_enable(read_enable),
        .chip_select(chip_select), .wr_data(wr_data), .sram_data_in(sram_data_in),
        .sram_addr(s_addr), .sram_data_out(s_data_out), .sram_data_drive(s_data_drive),
        .sram_we_n(s_we_n), .sram_oe_n(s_oe_n), .sram_cs_n(s_cs_n),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .wrap(s_wrap),
        .wr_checksum(s_wr_checksum), .rd_checksum(s_rd_checksum)
    );

    task automatic set_idle();
        increment     = 1'b0;
        latch         = 1'b0;
        data_valid    = 1'b0;
        output_enable = 1'b1;
        read_enable   = 1'b1;
        chip_select   = 1'b1;
        wr_data       = 8'h00;
        sram_data_in  = 8'h00;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        set_idle();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        read_enable = 1'b0; data_valid = 1'b1; output_enable = 1'b0; chip_select = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin fails++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
        checks++; if (sram_data_drive !== 1'b0) begin fails++; $display("FAIL reset_drive: got %b expected 0", sram_data_drive); end
        checks++; if (sram_oe_n !== 1'b1) begin fails++; $display("FAIL reset_oe_n: got %b expected 1", sram_oe_n); end
        checks++; if (sram_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n: got %b expected 1", sram_cs_n); end
        checks++; if (sram_addr !== 11'd0) begin fails++; $display("FAIL reset_addr: got %0d expected 0", sram_addr); end
        checks++; if ({sram_data_out, rd_data, wr_checksum, rd_checksum} !== 32'h0) begin
            fails++; $display("FAIL reset_regs: got %h expected 0", {sram_data_out, rd_data, wr_checksum, rd_checksum}); end
        checks++; if ({rd_valid, wrap} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b expected 00", {rd_valid, wrap}); end
        $display("reset: outputs held at reset values");
        @(negedge clock);
        set_idle();
        reset = 1'b0;
    endtask

    task automatic test_write_latch();
        @(negedge clock);
        read_enable = 1'b0;            // enter write mode
        step();
        @(negedge clock);
        wr_data = 8'hA5; latch = 1'b1;
        step();
        checks++; if (sram_data_out !== 8'hA5) begin fails++; $display("FAIL latch_data: got %h expected a5", sram_data_out); end
        checks++; if (wr_checksum !== 8'hA5) begin fails++; $display("FAIL latch_sum: got %h expected a5", wr_checksum); end
        checks++; if (sram_data_drive !== 1'b1) begin fails++; $display("FAIL latch_drive: got %b expected 1", sram_data_drive); end
        $display("write latch: data_out=%h wr_checksum=%h", sram_data_out, wr_checksum);
        @(negedge clock);
        latch = 1'b0;
    endtask

    task automatic test_strobes();
        @(negedge clock);
        data_valid = 1'b1; output_enable = 1'b0; chip_select = 1'b0;
        #1;
        checks++; if (sram_we_n !== 1'b0) begin fails++; $display("FAIL we_write: got %b expected 0", sram_we_n); end
        checks++; if ({sram_oe_n, sram_cs_n} !== 2'b00) begin fails++; $display("FAIL oe_cs: got %b expected 00", {sram_oe_n, sram_cs_n}); end
        read_enable = 1'b1;
        #1;
        checks++; if (sram_we_n !== 1'b1) begin fails++; $display("FAIL we_read: got %b expected 1", sram_we_n); end
        checks++; if (sram_data_drive !== 1'b0) begin fails++; $display("FAIL drive_read: got %b expected 0", sram_data_drive); end
        $display("strobes: we_n tracks write-mode data_valid");
        read_enable = 1'b0; data_valid = 1'b0; output_enable = 1'b1; chip_select = 1'b1;
    endtask

    task automatic test_increment();
        // Still in write mode at address 0; last step also latches (increment+latch together).
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            increment = 1'b1;
            if (i == 3) begin latch = 1'b1; wr_data = 8'h5A; end
            checks++; if (sram_addr !== 11'(i - 1)) begin fails++; $display("FAIL inc_latency%0d: got %0d expected %0d", i, sram_addr, i - 1); end
            step();
            checks++; if (sram_addr !== 11'(i)) begin fails++; $display("FAIL inc_addr%0d: got %0d expected %0d", i, sram_addr, i); end
            checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL inc_wrap%0d: got %b expected 0", i, wrap); end
            $display("increment %0d: addr=%0d", i, sram_addr);
            @(negedge clock);
            increment = 1'b0; latch = 1'b0;
        end
        checks++; if (wr_checksum !== 8'hFF) begin fails++; $display("FAIL inc_latch_sum: got %h expected ff", wr_checksum); end
        checks++; if (sram_data_out !== 8'h5A) begin fails++; $display("FAIL inc_latch_data: got %h expected 5a", sram_data_out); end
    endtask

    task automatic test_wrap_small();
        logic [10:0] exp_addr [4];
        exp_addr = '{11'd1, 11'd2, 11'd3, 11'd0};
        do_reset();
        increment = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (s_addr !== exp_addr[i]) begin fails++; $display("FAIL small_addr%0d: got %0d expected %0d", i, s_addr, exp_addr[i]); end
            checks++; if (s_wrap !== (i == 3)) begin fails++; $display("FAIL small_wrap%0d: got %b expected %b", i, s_wrap, (i == 3)); end
            $display("small counter edge %0d: addr=%0d wrap=%b", i, s_addr, s_wrap);
        end
        @(negedge clock);
        increment = 1'b0;
        step();
        checks++; if (s_wrap !== 1'b0) begin fails++; $display("FAIL small_wrap_pulse: got %b expected 0", s_wrap); end
        checks++; if (s_addr !== 11'd0) begin fails++; $display("FAIL small_hold: got %0d expected 0", s_addr); end
        checks++; if (sram_addr !== 11'd4) begin fails++; $display("FAIL big_after4: got %0d expected 4", sram_addr); end
    endtask

    task automatic test_wrap_full();
        do_reset();
        increment = 1'b1;
        repeat (2047) @(posedge clock);
        #1;
        checks++; if (sram_addr !== 11'd2047) begin fails++; $display("FAIL full_last: got %0d expected 2047", sram_addr); end
        checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL full_prewrap: got %b expected 0", wrap); end
        @(negedge clock);
        increment = 1'b0;
        increment = 1'b1;
        step();
        checks++; if (sram_addr !== 11'd0 || wrap !== 1'b1) begin
            fails++; $display("FAIL full_wrap: got addr %0d wrap %b expected addr 0 wrap 1", sram_addr, wrap); end
        $display("full counter wrap: addr=%0d wrap=%b", sram_addr, wrap);
        @(negedge clock);
        increment = 1'b0;
        step();
        checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL full_wrap_pulse: got %b expected 0", wrap); end
    endtask

    // Drives read captures for the listed words on consecutive cycles and checks each rd_valid against the queue.
    task automatic read_burst(input logic [7:0] words [$]);
        int pulses;
        pulses = 0;
        for (int i = 0; i < words.size(); i++) begin
            @(negedge clock);
            sram_data_in = words[i]; output_enable = 1'b0; data_valid = 1'b0;
            exp_q.push_back(words[i]);
            step();
            if (rd_valid === 1'b1) begin
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin fails++; $display("FAIL rd_unexpected: got %h expected none", rd_data); end
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (rd_data !== e) begin fails++; $display("FAIL rd_data: got %h expected %h", rd_data, e); end
                end
                $display("read capture: rd_data=%h rd_checksum=%h", rd_data, rd_checksum);
            end
        end
        @(negedge clock);
        output_enable = 1'b1;
        step();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
        checks++; if (pulses != words.size()) begin fails++; $display("FAIL rd_pulses: got %0d expected %0d", pulses, words.size()); end
        checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL rd_queue: got %0d pending expected 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_read_capture();
        logic [7:0] w [$];
        do_reset();
        w = '{8'h3C};
        read_burst(w);
        checks++; if (rd_checksum !== 8'h3C) begin fails++; $display("FAIL rd_sum1: got %h expected 3c", rd_checksum); end
        w = '{8'hF0};
        read_burst(w);
        checks++; if (rd_checksum !== 8'h2C) begin fails++; $display("FAIL rd_sum2: got %h expected 2c", rd_checksum); end
        w = '{8'h01, 8'h02, 8'h03};
        read_burst(w);
        checks++; if (rd_checksum !== 8'h32) begin fails++; $display("FAIL rd_sum3: got %h expected 32", rd_checksum); end
    endtask

    task automatic test_mode_change();
        logic [7:0] w [$];
        do_reset();
        @(negedge clock); read_enable = 1'b0;                 // enter write
        @(negedge clock); wr_data = 8'h11; latch = 1'b1;
        @(negedge clock); latch = 1'b0; read_enable = 1'b1;  // back to read
        step();
        w = '{8'h3C};
        read_burst(w);
        @(negedge clock); increment = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        checks++; if (sram_addr !== 11'd5) begin fails++; $display("FAIL mc_pre_addr: got %0d expected 5", sram_addr); end
        checks++; if (wr_checksum !== 8'h11) begin fails++; $display("FAIL mc_pre_sum: got %h expected 11", wr_checksum); end
        @(negedge clock);
        read_enable = 1'b0;                                   // increment still high
        step();
        checks++; if (sram_addr !== 11'd0) begin fails++; $display("FAIL mc_addr: got %0d expected 0", sram_addr); end
        checks++; if (wrap !== 1'b0) begin fails++; $display("FAIL mc_wrap: got %b expected 0", wrap); end
        checks++; if (wr_checksum !== 8'h00) begin fails++; $display("FAIL mc_wr_sum: got %h expected 00", wr_checksum); end
        $display("mode change to write: addr=%0d wr_checksum=%h", sram_addr, wr_checksum);
        @(negedge clock);
        increment = 1'b0; read_enable = 1'b1; output_enable = 1'b0; data_valid = 1'b0; sram_data_in = 8'h77;
        step();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mc_no_capture: got %b expected 0", rd_valid); end
        checks++; if (rd_checksum !== 8'h00) begin fails++; $display("FAIL mc_rd_sum: got %h expected 00", rd_checksum); end
        checks++; if (rd_data !== 8'h3C) begin fails++; $display("FAIL mc_rd_data: got %h expected 3c", rd_data); end
        $display("mode change to read: rd_checksum=%h rd_data=%h", rd_checksum, rd_data);
        @(negedge clock);
        output_enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_write();
        @(negedge clock); read_enable = 1'b0;
        @(negedge clock); wr_data = 8'hA5; latch = 1'b1; data_valid = 1'b1; increment = 1'b1;
        step();
        checks++; if (sram_we_n !== 1'b0 || sram_data_out !== 8'hA5) begin
            fails++; $display("FAIL midw_pre: got we_n %b data %h expected 0 a5", sram_we_n, sram_data_out); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({sram_data_out, wr_checksum} !== 16'h0) begin fails++; $display("FAIL midw_regs: got %h expected 0000", {sram_data_out, wr_checksum}); end
        checks++; if (sram_addr !== 11'd0) begin fails++; $display("FAIL midw_addr: got %0d expected 0", sram_addr); end
        checks++; if ({sram_we_n, sram_data_drive} !== 2'b10) begin fails++; $display("FAIL midw_strobes: got %b expected 10", {sram_we_n, sram_data_drive}); end
        $display("reset mid-write: addr=%0d data_out=%h", sram_addr, sram_data_out);
        @(negedge clock);
        reset = 1'b0; latch = 1'b0; data_valid = 1'b0; increment = 1'b0;
        step();
        checks++; if (sram_addr !== 11'd0) begin fails++; $display("FAIL midw_restart: got %0d expected 0", sram_addr); end
        @(negedge clock); increment = 1'b1;
        step();
        checks++; if (sram_addr !== 11'd1) begin fails++; $display("FAIL midw_next: got %0d expected 1", sram_addr); end
        @(negedge clock); increment = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_idle();
        test_reset();
        test_write_latch();
        test_strobes();
        test_increment();
        test_wrap_small();
        test_wrap_full();
        test_read_capture();
        test_mode_change();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_sram_datapath
